systolic_feeder: RTL and testbench

//   Upstream input stage of the N x N systolic PE array. Buffers one N x N A matrix and one
//   N x N B matrix, then drives the array's left edge (a lanes) and top edge (b lanes) with the

---
 rtl/systolic_feeder_if.sv | 9 +
 rtl/systolic_feeder.sv | 85 ++++++++
 tb/tb_systolic_feeder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: job start, A/B operand load channel and skewed array-edge outputs.
interface systolic_feeder_if #(parameter int N = 4, parameter int DW = 8);
    logic            start, load_valid, load_ready, pe_clr, busy, done;
    logic [N*DW-1:0] load_a, load_b, a_edge, b_edge;
    modport master (output start, load_valid, load_a, load_b,
                    input  load_ready, a_edge, b_edge, pe_clr, busy, done);
    modport slave  (input  start, load_valid, load_a, load_b,
                    output load_ready, a_edge, b_edge, pe_clr, busy, done);
endinterface

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers one A and one B matrix, then streams them diagonally skewed
// onto the left (a) and top (b) edges of an N x N systolic PE array.
module systolic_feeder #(parameter int N = 4, parameter int DW = 8) (
    input logic             clk_i,
    input logic             rst_ni,
    systolic_feeder_if.slave bus
);
    localparam int CW = $clog2(2 * N);
    localparam int AW = $clog2(N);
    localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, STREAM = 3'd2, FLUSH = 3'd3, DONE = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N*DW-1:0] a_q, a_d, b_q, b_d;
    logic [N*DW-1:0] buf_a_q [N];
    logic [N*DW-1:0] buf_b_q [N];
    logic            fire, last;

    assign fire = state_q == LOAD && bus.load_valid;
    assign last = fire && cnt_q == CW'(N - 1);

    // cnt doubles as the load beat index in LOAD and the step counter in STREAM/FLUSH
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                state_d = bus.start ? LOAD : IDLE;
                cnt_d   = '0;
            end
            LOAD: begin
                cnt_d   = last ? '0 : cnt_q + CW'(fire);
                state_d = last ? STREAM : LOAD;
            end
            STREAM: begin
                state_d = cnt_q == CW'(2 * N - 2) ? FLUSH : STREAM;
                cnt_d   = cnt_q == CW'(2 * N - 2) ? '0 : cnt_q + 1'b1;
            end
            FLUSH: begin
                state_d = cnt_q == CW'(N - 2) ? DONE : FLUSH;
                cnt_d   = cnt_q == CW'(N - 2) ? '0 : cnt_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Edge values are computed from the next step so the registered lanes line up with t
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [CW-1:0] d;
        logic          hit;
        assign d   = cnt_d - CW'(i);
        assign hit = state_d == STREAM && cnt_d >= CW'(i) && d < CW'(N);
        assign a_d[i*DW +: DW] = hit ? buf_a_q[d[AW-1:0]][i*DW +: DW] : '0;
        assign b_d[i*DW +: DW] = hit ? buf_b_q[d[AW-1:0]][i*DW +: DW] : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end

    always_ff @(posedge clk_i)
        if (fire) begin
            buf_a_q[cnt_q[AW-1:0]] <= bus.load_a;
            buf_b_q[cnt_q[AW-1:0]] <= bus.load_b;
        end

    assign bus.load_ready = state_q == LOAD;
    assign bus.pe_clr     = last;
    assign bus.busy       = state_q != IDLE;
    assign bus.done       = state_q == DONE;
    assign bus.a_edge     = a_q;
    assign bus.b_edge     = b_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed checks of load handshake, skewed streaming, timing and abort.
module tb_systolic_feeder;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    systolic_feeder_if #(.N(4), .DW(8)) bus ();
    systolic_feeder #(.N(4), .DW(8)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_a(input int k);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[i*8 +: 8] = 8'(16 * i + k + 1);
        return v;
    endfunction

    function automatic logic [31:0] beat_b(input int k);
        logic [31:0] v;
        for (int j = 0; j < 4; j++) v[j*8 +: 8] = 8'(16 * k + j + 'h81);
        return v;
    endfunction

    function automatic logic [31:0] exp_a(input int t);
        logic [31:0] v = '0;
        for (int i = 0; i < 4; i++)
            if (t - i >= 0 && t - i < 4) v[i*8 +: 8] = 8'(16 * i + (t - i) + 1);
        return v;
    endfunction

    function automatic logic [31:0] exp_b(input int t);
        logic [31:0] v = '0;
        for (int j = 0; j < 4; j++)
            if (t - j >= 0 && t - j < 4) v[j*8 +: 8] = 8'(16 * (t - j) + j + 'h81);
        return v;
    endfunction

    task automatic run_job(input logic [15:0] pat, input int len, input int busy_t, input int abort_t);
        int kb = 0;
        chk("idle_busy", 32'(bus.busy), 0);
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        #1;
        chk("busy_after_start", 32'(bus.busy), 1);
        for (int p = 0; p < len; p++) begin
            bus.load_valid = pat[p];
            bus.load_a = beat_a(kb);
            bus.load_b = beat_b(kb);
            #1;
            chk("load_ready", 32'(bus.load_ready), 1);
            chk("pe_clr_load", 32'(bus.pe_clr), 32'(pat[p] && kb == 3));
            tick;
            if (pat[p]) kb++;
        end
        bus.load_valid = 1'b0;
        bus.load_a = '0;
        bus.load_b = '0;
        #1;
        chk("ready_drop", 32'(bus.load_ready), 0);
        for (int t = 0; t < 7; t++) begin
            if (t == abort_t) begin
                rst_n = 1'b0;
                #1;
                chk("abort_a", bus.a_edge, 0);
                chk("abort_b", bus.b_edge, 0);
                chk("abort_busy", 32'(bus.busy), 0);
                chk("abort_done", 32'(bus.done), 0);
                chk("abort_ready", 32'(bus.load_ready), 0);
                chk("abort_pe_clr", 32'(bus.pe_clr), 0);
                #1 rst_n = 1'b1;
                return;
            end
            bus.start = 1'(t == busy_t);
            #1;
            chk($sformatf("a_t%0d", t), bus.a_edge, exp_a(t));
            chk($sformatf("b_t%0d", t), bus.b_edge, exp_b(t));
            chk("pe_clr_stream", 32'(bus.pe_clr), 0);
            chk("done_stream", 32'(bus.done), 0);
            chk("busy_stream", 32'(bus.busy), 1);
            case (t)
                0: chk("spot_t0_a", bus.a_edge, 32'h0000_0001);
                1: begin
                    chk("spot_t1_a1", 32'(bus.a_edge[15:8]), 32'h11);
                    chk("spot_t1_b1", 32'(bus.b_edge[15:8]), 32'h82);
                end
                3: begin
                    chk("spot_t3_a3", 32'(bus.a_edge[31:24]), 32'h31);
                    chk("spot_t3_a0", 32'(bus.a_edge[7:0]), 32'h04);
                end
                6: begin
                    chk("spot_t6_a", bus.a_edge, 32'h3400_0000);
                    chk("spot_t6_b", bus.b_edge, 32'hB400_0000);
                end
                default: ;
            endcase
            tick;
        end
        bus.start = 1'b0;
        repeat (3) begin
            #1;
            chk("flush_a", bus.a_edge, 0);
            chk("flush_b", bus.b_edge, 0);
            chk("flush_done", 32'(bus.done), 0);
            chk("flush_busy", 32'(bus.busy), 1);
            tick;
        end
        #1;
        chk("done_pulse", 32'(bus.done), 1);
        chk("done_busy", 32'(bus.busy), 1);
        tick;
        chk("done_low", 32'(bus.done), 0);
        chk("busy_low", 32'(bus.busy), 0);
    endtask

    initial begin
        rst_n = 1'b1;
        bus.start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_a = '0;
        bus.load_b = '0;
        #2 rst_n = 1'b0;
        repeat (4) begin
            tick;
            bus.start = 1'($urandom);
            bus.load_valid = 1'($urandom);
            bus.load_a = $urandom;
            bus.load_b = $urandom;
            #1;
            chk("rst_a", bus.a_edge, 0);
            chk("rst_b", bus.b_edge, 0);
            chk("rst_ready", 32'(bus.load_ready), 0);
            chk("rst_pe_clr", 32'(bus.pe_clr), 0);
            chk("rst_busy", 32'(bus.busy), 0);
            chk("rst_done", 32'(bus.done), 0);
        end
        bus.start = 1'b0;
        bus.load_valid = 1'b1;
        rst_n = 1'b1;
        repeat (3) begin
            tick;
            chk("idle_ready", 32'(bus.load_ready), 0);
            chk("idle_no_busy", 32'(bus.busy), 0);
        end
        bus.load_valid = 1'b0;
        tick;
        run_job(16'h000F, 4, -1, -1);
        tick;
        run_job(16'b1101001, 7, -1, -1);
        tick;
        run_job(16'h000F, 4, 2, -1);
        repeat (2) begin
            tick;
            chk("after_busy_start", 32'(bus.busy), 0);
        end
        run_job(16'h000F, 4, -1, -1);
        tick;
        run_job(16'h000F, 4, -1, 3);
        tick;
        chk("post_abort_idle", 32'(bus.busy), 0);
        run_job(16'h000F, 4, -1, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
